// File: rtl/i2c_slave_ctrl.sv
// I2C slave byte-level controller: synchronizes the pad signals, detects START/STOP,
// ACKs a matched address, receives write bytes and serializes read bytes onto SDA.
module i2c_slave_ctrl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       addr_load,
    input  logic       comp,
    output logic       rw,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_req,
    input  logic [7:0] tx_data,
    output logic       busy
);
    localparam int STAGES_C = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        ADDR_ACK  = 3'd2,
        WRITE     = 3'd3,
        WRITE_ACK = 3'd4,
        READ      = 3'd5,
        READ_ACK  = 3'd6
    } state_t;

    logic [STAGES_C-1:0] scl_sync_r;
    logic [STAGES_C-1:0] sda_sync_r;
    logic                scl_d_r;
    logic                sda_d_r;
    logic                scl_s;
    logic                sda_s;
    logic                scl_rise_s;
    logic                scl_fall_s;
    logic                start_s;
    logic                stop_s;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [3:0]          cnt_r;
    logic [3:0]          cnt_nxt_s;
    logic [7:0]          shift_r;
    logic [7:0]          shift_nxt_s;
    logic                sda_oe_r;
    logic                sda_oe_nxt_s;
    logic                addr_load_r;
    logic                addr_load_nxt_s;
    logic                rw_r;
    logic                rw_nxt_s;
    logic [7:0]          rx_data_r;
    logic [7:0]          rx_data_nxt_s;
    logic                rx_valid_r;
    logic                rx_valid_nxt_s;
    logic                busy_r;
    logic                tx_req_s;

    // Pad synchronizers plus one-clk-delayed copies; idle bus level is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync_r <= {STAGES_C{1'b1}};
            sda_sync_r <= {STAGES_C{1'b1}};
            scl_d_r    <= 1'b1;
            sda_d_r    <= 1'b1;
        end else begin
            scl_sync_r <= {scl_sync_r[STAGES_C-2:0], scl_in};
            sda_sync_r <= {sda_sync_r[STAGES_C-2:0], sda_in};
            scl_d_r    <= scl_sync_r[STAGES_C-1];
            sda_d_r    <= sda_sync_r[STAGES_C-1];
        end
    end

    assign scl_s      = scl_sync_r[STAGES_C-1];
    assign sda_s      = sda_sync_r[STAGES_C-1];
    assign scl_rise_s = scl_s & ~scl_d_r;
    assign scl_fall_s = ~scl_s & scl_d_r;
    assign start_s    = scl_s & scl_d_r & sda_d_r & ~sda_s;
    assign stop_s     = scl_s & scl_d_r & ~sda_d_r & sda_s;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= 4'd0;
            shift_r     <= 8'h00;
            sda_oe_r    <= 1'b0;
            addr_load_r <= 1'b0;
            rw_r        <= 1'b0;
            rx_data_r   <= 8'h00;
            rx_valid_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            shift_r     <= shift_nxt_s;
            sda_oe_r    <= sda_oe_nxt_s;
            addr_load_r <= addr_load_nxt_s;
            rw_r        <= rw_nxt_s;
            rx_data_r   <= rx_data_nxt_s;
            rx_valid_r  <= rx_valid_nxt_s;
            busy_r      <= (state_nxt_s != IDLE);
        end
    end

    // Next-state logic; bus conditions outrank bit processing.
    always_comb begin
        state_nxt_s = state_r;
        if (start_s) begin
            state_nxt_s = ADDR;
        end else if (stop_s) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    state_nxt_s = IDLE;
                end
                ADDR: begin
                    if (scl_rise_s && (cnt_r == 4'd7)) begin
                        state_nxt_s = comp ? ADDR_ACK : IDLE;
                    end else begin
                        state_nxt_s = ADDR;
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall_s && (cnt_r == 4'd0)) begin
                        state_nxt_s = rw_r ? READ : WRITE;
                    end else begin
                        state_nxt_s = ADDR_ACK;
                    end
                end
                WRITE: begin
                    if (scl_rise_s && (cnt_r == 4'd7)) begin
                        state_nxt_s = WRITE_ACK;
                    end else begin
                        state_nxt_s = WRITE;
                    end
                end
                WRITE_ACK: begin
                    if (scl_fall_s && (cnt_r == 4'd0)) begin
                        state_nxt_s = WRITE;
                    end else begin
                        state_nxt_s = WRITE_ACK;
                    end
                end
                READ: begin
                    if (scl_fall_s && (cnt_r == 4'd8)) begin
                        state_nxt_s = READ_ACK;
                    end else begin
                        state_nxt_s = READ;
                    end
                end
                READ_ACK: begin
                    if (scl_rise_s && (cnt_r == 4'd8)) begin
                        state_nxt_s = sda_s ? IDLE : READ_ACK;
                    end else if (scl_fall_s && (cnt_r == 4'd0)) begin
                        state_nxt_s = READ;
                    end else begin
                        state_nxt_s = READ_ACK;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    // Output and datapath next values. In the ACK states the counter sits at 8
    // until the 9th rising edge wraps it to 0, which marks the ACK-ending fall.
    always_comb begin
        cnt_nxt_s       = cnt_r;
        shift_nxt_s     = shift_r;
        sda_oe_nxt_s    = sda_oe_r;
        addr_load_nxt_s = addr_load_r;
        rw_nxt_s        = rw_r;
        rx_data_nxt_s   = rx_data_r;
        rx_valid_nxt_s  = 1'b0;
        tx_req_s        = 1'b0;
        if (start_s || stop_s) begin
            cnt_nxt_s       = 4'd0;
            sda_oe_nxt_s    = 1'b0;
            addr_load_nxt_s = 1'b0;
        end else begin
            case (state_r)
                ADDR, WRITE: begin
                    if (scl_rise_s) begin
                        shift_nxt_s = {shift_r[6:0], sda_s};
                        cnt_nxt_s   = cnt_r + 4'd1;
                        if ((state_r == ADDR) && (cnt_r == 4'd6)) begin
                            addr_load_nxt_s = 1'b1;
                        end else if ((state_r == ADDR) && (cnt_r == 4'd7)) begin
                            addr_load_nxt_s = 1'b0;
                            rw_nxt_s        = sda_s;
                        end else if ((state_r == WRITE) && (cnt_r == 4'd7)) begin
                            rx_data_nxt_s  = {shift_r[6:0], sda_s};
                            rx_valid_nxt_s = 1'b1;
                        end else begin
                            addr_load_nxt_s = addr_load_r;
                        end
                    end else begin
                        cnt_nxt_s = cnt_r;
                    end
                end
                ADDR_ACK, WRITE_ACK, READ_ACK: begin
                    if (scl_fall_s && (cnt_r == 4'd8)) begin
                        sda_oe_nxt_s = (state_r != READ_ACK);
                    end else if (scl_rise_s && (cnt_r == 4'd8)) begin
                        cnt_nxt_s = 4'd0;
                    end else if (scl_fall_s && (cnt_r == 4'd0)) begin
                        if ((state_r == READ_ACK) || ((state_r == ADDR_ACK) && rw_r)) begin
                            tx_req_s     = 1'b1;
                            shift_nxt_s  = {tx_data[6:0], 1'b0};
                            sda_oe_nxt_s = ~tx_data[7];
                        end else begin
                            sda_oe_nxt_s = 1'b0;
                        end
                    end else begin
                        cnt_nxt_s = cnt_r;
                    end
                end
                READ: begin
                    if (scl_rise_s) begin
                        cnt_nxt_s = (cnt_r < 4'd8) ? (cnt_r + 4'd1) : cnt_r;
                    end else if (scl_fall_s && (cnt_r == 4'd8)) begin
                        sda_oe_nxt_s = 1'b0;
                    end else if (scl_fall_s && (cnt_r != 4'd0)) begin
                        sda_oe_nxt_s = ~shift_r[7];
                        shift_nxt_s  = {shift_r[6:0], 1'b0};
                    end else begin
                        cnt_nxt_s = cnt_r;
                    end
                end
                default: begin
                    cnt_nxt_s = cnt_r;
                end
            endcase
        end
    end

    assign sda_oe    = sda_oe_r;
    assign addr_load = addr_load_r;
    assign rw        = rw_r;
    assign rx_data   = rx_data_r;
    assign rx_valid  = rx_valid_r;
    assign busy      = busy_r;
    assign tx_req    = tx_req_s & ~reset;

endmodule

// File: doc/i2c_slave_ctrl.md
I2C_SLAVE_CTRL -- requirements
Module: i2c_slave_ctrl

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, meaning the number of synchronizer flops on scl_in and sda_in (minimum 2).
REQ-002 The block SHALL have port clk, input, 1 bit, the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-004 The block SHALL have port scl_in, input, 1 bit, raw I2C clock from the pad.
REQ-005 The block SHALL have port sda_in, input, 1 bit, raw I2C data from the pad.
REQ-006 The block SHALL have port sda_oe, output, 1 bit: 1 = pull SDA low, 0 = release SDA.
REQ-007 The block SHALL have port addr_load, output, 1 bit, feeding the load input of the downstream address comparator.
REQ-008 The block SHALL have port comp, input, 1 bit, address-match result from the comparator (match AND addr_load).
REQ-009 The block SHALL have port rw, output, 1 bit, latched R/W bit of the current transfer (1 = read).
REQ-010 The block SHALL have port rx_data, output, 8 bits, last byte written by the master.
REQ-011 The block SHALL have port rx_valid, output, 1 bit, one-clk pulse when rx_data updates.
REQ-012 The block SHALL have port tx_req, output, 1 bit, one-clk pulse requesting the next read byte.
REQ-013 The block SHALL have port tx_data, input, 8 bits, read byte, sampled in the tx_req cycle.
REQ-014 The block SHALL have port busy, output, 1 bit, high in every state except IDLE.

Function
REQ-015 scl_in/sda_in SHALL pass through SYNC_STAGES flops; edges are detected by comparing each synchronized value against a one-clk-delayed copy.
REQ-016 START SHALL be detected when synchronized scl is high in both samples and sda goes 1->0; STOP when scl is high in both samples and sda goes 0->1.
REQ-017 Data bits SHALL be sampled on the scl rising-edge cycle, MSB first; sda_oe SHALL change only on the scl falling-edge cycle, or on START, STOP or reset.
REQ-018 States: IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK; a 4-bit counter SHALL count scl rising edges within a byte, 0..8.
REQ-019 START in any state, including a repeated START, SHALL move to ADDR, clear the bit counter and set sda_oe=0.
REQ-020 STOP in any state SHALL move to IDLE with sda_oe=0.
REQ-021 ADDR: addr_load SHALL go high the clk after the 7th rising edge and fall the clk after the 8th rising edge.
REQ-022 At the 8th rising edge, the block SHALL latch rw=sda and sample comp in the same cycle.
REQ-023 If the sampled comp=1, the block SHALL go to ADDR_ACK and set sda_oe=1 at the next scl falling edge; if comp=0, it SHALL go to IDLE and ignore the bus until the next START.
REQ-024 ADDR_ACK: sda_oe SHALL be held through the 9th scl pulse and released at the 9th falling edge, entering WRITE if rw=0 or READ if rw=1.
REQ-025 WRITE: after the 8th rising edge, rx_data SHALL update and rx_valid SHALL pulse in the next clk; the block then enters WRITE_ACK.
REQ-026 WRITE_ACK: the block SHALL always ACK (sda_oe=1 for the 9th pulse), then return to WRITE for the next byte.
REQ-027 READ entry: tx_req SHALL pulse in the falling-edge cycle that ends the ACK, and tx_data SHALL be latched in that same cycle.
REQ-028 READ bit n SHALL be driven as sda_oe = ~bit.
REQ-029 After the 8th bit's falling edge, sda_oe SHALL be released and the block SHALL enter READ_ACK.
REQ-030 READ_ACK, 9th rising edge: sda=0 (ACK) SHALL continue READ with a new tx_req at the 9th falling edge; sda=1 (NACK) SHALL go to IDLE.
REQ-031 The bit counter SHALL wrap 8->0 only at byte boundaries and never exceed 8.
REQ-032 A START or STOP coincident with an scl edge in the same clk SHALL take priority over bit processing.

Reset
REQ-033 On reset=1 at a clk edge, the block SHALL enter IDLE with sda_oe=0, addr_load=0, rw=0, rx_data=0x00, rx_valid=0, tx_req=0 and busy=0, then ignore the bus until a fresh START.
REQ-034 Synchronizer flops SHALL reset to 1, the idle bus level.
REQ-035 Reset mid-transfer SHALL release SDA in the next clk.

Verification
REQ-036 START, address 0x40 + W, comp=1 during addr_load, data 0xA5 -> ACK after address and after data; rx_data=0xA5; rx_valid exactly one pulse; STOP -> busy=0.
REQ-037 START, address 0x41 + W, comp=0 -> no ACK (sda_oe stays 0), IDLE; subsequent data bytes are ignored with rx_valid=0.
REQ-038 START, address + R, comp=1, tx_data=0x3C then 0xFF; master ACKs byte 1 and NACKs byte 2 -> SDA pattern 00111100 then 11111111; two tx_req pulses; IDLE after the NACK.
REQ-039 Repeated START after a write byte, then a read -> the bit counter restarts at 0, rw=1, and addr_load pulses again.
REQ-040 reset asserted while driving a read bit 0 -> sda_oe=0 in the next clk and all outputs at reset values; a following STOP/START is handled normally.
